imem_boot_ctrl: RTL and testbench
=================================

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 Parameter DEPTH_BYTES SHALL default to 256 and set the instruction memory size in bytes, power of two, minimum 16.
REQ-002 Parameter PC_RESET SHALL default to 32'h0000_0000 and set the first fetch address after loading; it is word-aligned and below DEPTH_BYTES.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-low reset.
REQ-005 load_valid  input  1  SHALL flag that the host is offering a 32-bit instruction word.
REQ-006 load_data  input  32  SHALL carry the offered instruction word.
REQ-007 load_last  input  1  SHALL mark the offered word as the final word of the program.
REQ-008 load_ready  output  1  SHALL flag that the block accepts a word this cycle.
REQ-009 mem_we  output  1  SHALL be the byte write strobe to the instruction memory.
REQ-010 mem_waddr  output  $clog2(DEPTH_BYTES)  SHALL be the byte write address.
REQ-011 mem_wdata  output  8  SHALL be the byte write data.
REQ-012 stall  input  1  SHALL hold the PC when high during RUN.
REQ-013 branch_taken  input  1  SHALL request a PC redirect.
REQ-014 branch_target  input  32  SHALL be the redirect address.
REQ-015 pc  output  32  SHALL be the current fetch address.
REQ-016 run  output  1  SHALL be high only in RUN.
REQ-017 pc_err  output  1  SHALL be high only in HALT.

Function
REQ-018 The FSM SHALL use the states ACCEPT, WRITE, RUN and HALT.
REQ-019 ACCEPT: load_ready=1; on load_valid=1, capture load_data and load_last, then go to WRITE.
REQ-020 WRITE SHALL last exactly 4 cycles with mem_we=1 and load_ready=0.
- Bytes are written little-endian: data[7:0] first, data[31:24] last.
- Each byte goes to the write pointer, which then increments.
REQ-021 The write pointer SHALL wrap from DEPTH_BYTES-1 to 0 with no error.
REQ-022 After the 4th byte, the FSM SHALL go to RUN if the captured last flag is 1, else back to ACCEPT.
REQ-023 On entry to RUN, pc SHALL equal PC_RESET.
REQ-024 RUN PC update priority SHALL be stall > branch_taken > increment.
- stall=1: pc holds.
- branch_taken=1: pc <= branch_target modulo DEPTH_BYTES.
- otherwise: pc <= (pc+4) modulo DEPTH_BYTES.
REQ-025 load_valid SHALL be ignored outside ACCEPT, with load_ready=0.
REQ-026 HALT SHALL be sticky until reset; pc holds and mem_we=0.
REQ-027 mem_we SHALL be 0 in every state except WRITE.

Reset
REQ-028 With reset=0 at a clock edge, the block SHALL enter ACCEPT from any state, including mid-WRITE, and drop any partially written word.
REQ-029 Reset values SHALL be:
- load_ready=1, mem_we=0, mem_waddr=0, mem_wdata=0.
- pc=PC_RESET, run=0, pc_err=0.
- write pointer=0.

Configuration
REQ-030 With macro IMEM_ALIGN_CHECK_EN defined, a RUN cycle with stall=0, branch_taken=1 and branch_target[1:0]!=0 SHALL enter HALT, leave pc unchanged and set pc_err=1.
REQ-031 Without IMEM_ALIGN_CHECK_EN, branch_target[1:0] SHALL be forced to 0, HALT SHALL be unreachable, and pc_err SHALL be tied to 0.

Structure
REQ-032 Package imem_pkg SHALL hold:
- the state enum typedef;
- INSTR_BYTES=4;
- the PC increment constant 4.
REQ-033 Byte lane selection and pointer increment SHALL sit in the sub-module imem_byte_serializer; FSM and PC logic stay in imem_boot_ctrl.

Verification
REQ-034 Load one word 32'h0094_0333 with load_last=1 -> writes over 4 cycles: addr0=8'h33, addr1=8'h03, addr2=8'h94, addr3=8'h00; then run=1 and pc=0.
REQ-035 Load two words, the second with load_last=1, holding load_valid high throughout -> load_ready low for 4 cycles between accepts; second word lands at addr4..7.
REQ-036 In RUN with PC_RESET=0 and DEPTH_BYTES=16 -> pc sequence 0,4,8,12,0; stall=1 for 2 cycles holds pc.
REQ-037 In RUN with stall=1, branch_taken=1 and target 8 -> pc holds; release stall -> pc=8 on the next edge.
REQ-038 IMEM_ALIGN_CHECK_EN defined, target 32'h6 -> HALT, pc_err=1, pc held; undefined -> pc=4.
REQ-039 Reset asserted on the 2nd WRITE cycle -> next cycle in ACCEPT with mem_we=0 and write pointer=0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_WRITE  = 2'd1,
        ST_RUN    = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam int INSTR_BYTES = 4;
    localparam int PC_INC      = 4;
    localparam int BYTE_IDX_W  = $clog2(INSTR_BYTES);

endpackage

// File: rtl/imem_byte_serializer.sv
// Splits a captured 32-bit instruction word into little-endian bytes and
// tracks the byte write pointer into instruction memory.
module imem_byte_serializer
    import imem_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [31:0]   word_in,
    input  logic          advance,
    output logic [7:0]    byte_out,
    output logic [AW-1:0] addr_out,
    output logic          last_byte
);

    logic [31:0]           word_q;
    logic [BYTE_IDX_W-1:0] idx_q;
    logic [AW-1:0]         ptr_q;

    // NOTE: reset is synchronous, so it lives inside the edge-triggered block
    // and is simply the highest-priority branch; all state uses <= here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            word_q <= '0;
            idx_q  <= '0;
            ptr_q  <= '0;
        end else if (load) begin
            word_q <= word_in;
            idx_q  <= '0;
        end else if (advance) begin
            idx_q <= idx_q + 1'b1;
            ptr_q <= ptr_q + 1'b1;  // wraps naturally at DEPTH_BYTES
        end
    end

    always_comb begin
        byte_out = word_q[7:0];
        case (idx_q)
            2'd0: byte_out = word_q[7:0];
            2'd1: byte_out = word_q[15:8];
            2'd2: byte_out = word_q[23:16];
            2'd3: byte_out = word_q[31:24];
            default: byte_out = word_q[7:0];
        endcase
    end

    assign addr_out  = ptr_q;
    assign last_byte = (idx_q == BYTE_IDX_W'(INSTR_BYTES - 1));

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader / fetch-PC controller: streams host words into byte-wide IMEM,
// then runs the PC. Define IMEM_ALIGN_CHECK_EN to halt on misaligned branches.
module imem_boot_ctrl
    import imem_pkg::*;
#(
    parameter int          DEPTH_BYTES = 256,
    parameter logic [31:0] PC_RESET    = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load_valid,
    input  logic [31:0]                    load_data,
    input  logic                           load_last,
    output logic                           load_ready,
    output logic                           mem_we,
    output logic [$clog2(DEPTH_BYTES)-1:0] mem_waddr,
    output logic [7:0]                     mem_wdata,
    input  logic                           stall,
    input  logic                           branch_taken,
    input  logic [31:0]                    branch_target,
    output logic [31:0]                    pc,
    output logic                           run,
    output logic                           pc_err
);

    localparam int AW = $clog2(DEPTH_BYTES);

    state_t        state;
    logic          last_q;
    logic [AW-1:0] pc_q;
    logic          last_byte;
    logic          misaligned;
    logic [AW-1:0] tgt;
    logic          unused_tgt;

    // Targets are taken modulo the memory size and always word-aligned.
    assign tgt        = {branch_target[AW-1:2], 2'b00};
    assign unused_tgt = ^{branch_target[31:AW], branch_target[1:0]};

`ifdef IMEM_ALIGN_CHECK_EN
    assign misaligned = |branch_target[1:0];
    assign pc_err     = (state == ST_HALT);
`else
    assign misaligned = 1'b0;
    assign pc_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_ACCEPT;
            last_q <= 1'b0;
            pc_q   <= PC_RESET[AW-1:0];
        end else begin
            case (state)
                ST_ACCEPT: begin
                    if (load_valid) begin
                        last_q <= load_last;
                        state  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (last_byte) begin
                        state <= last_q ? ST_RUN : ST_ACCEPT;
                        pc_q  <= PC_RESET[AW-1:0];
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (branch_taken) begin
                            if (misaligned) state <= ST_HALT;
                            else            pc_q  <= tgt;
                        end else begin
                            pc_q <= pc_q + AW'(PC_INC);
                        end
                    end
                end
                default: ;  // HALT is sticky until reset
            endcase
        end
    end

    imem_byte_serializer #(.AW(AW)) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      ((state == ST_ACCEPT) && load_valid),
        .word_in   (load_data),
        .advance   (state == ST_WRITE),
        .byte_out  (mem_wdata),
        .addr_out  (mem_waddr),
        .last_byte (last_byte)
    );

    assign load_ready = (state == ST_ACCEPT);
    assign mem_we     = (state == ST_WRITE);
    assign run        = (state == ST_RUN);
    assign pc         = {{(32-AW){1'b0}}, pc_q};

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed self-checking bench for imem_boot_ctrl (DEPTH_BYTES=16, PC_RESET=0).
module tb_imem_boot_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        mem_we;
    logic [3:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic        run;
    logic        pc_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imem_boot_ctrl #(.DEPTH_BYTES(16), .PC_RESET(32'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .mem_we        (mem_we),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .run           (run),
        .pc_err        (pc_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_byte(input string tag, input logic [3:0] addr, input logic [7:0] data);
        check({tag, " we"},    {31'd0, mem_we}, 32'd1);
        check({tag, " ready"}, {31'd0, load_ready}, 32'd0);
        check({tag, " addr"},  {28'd0, mem_waddr}, {28'd0, addr});
        check({tag, " data"},  {24'd0, mem_wdata}, {24'd0, data});
    endtask

    initial begin
        reset = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        step(); step();

        check("rst load_ready", {31'd0, load_ready}, 32'd1);
        check("rst mem_we",     {31'd0, mem_we}, 32'd0);
        check("rst mem_waddr",  {28'd0, mem_waddr}, 32'd0);
        check("rst mem_wdata",  {24'd0, mem_wdata}, 32'd0);
        check("rst pc",         pc, 32'd0);
        check("rst run",        {31'd0, run}, 32'd0);
        check("rst pc_err",     {31'd0, pc_err}, 32'd0);

        // Reset during the second WRITE cycle drops the partial word.
        reset = 1'b1; load_valid = 1'b1; load_data = 32'h1122_3344; load_last = 1'b1;
        step();
        check_byte("abort w0", 4'd0, 8'h44);
        load_valid = 1'b0;
        step();
        check_byte("abort w1", 4'd1, 8'h33);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("abort mem_we", {31'd0, mem_we}, 32'd0);
        check("abort waddr",  {28'd0, mem_waddr}, 32'd0);
        check("abort ready",  {31'd0, load_ready}, 32'd1);
        check("abort run",    {31'd0, run}, 32'd0);

        // Two back-to-back words with load_valid held high.
        load_valid = 1'b1; load_data = 32'h0094_0333; load_last = 1'b0;
        step(); check_byte("w0 b0", 4'd0, 8'h33);
        step(); check_byte("w0 b1", 4'd1, 8'h03);
        step(); check_byte("w0 b2", 4'd2, 8'h94);
        step(); check_byte("w0 b3", 4'd3, 8'h00);
        load_data = 32'hDEAD_BEEF; load_last = 1'b1;
        step();
        check("gap ready",  {31'd0, load_ready}, 32'd1);
        check("gap mem_we", {31'd0, mem_we}, 32'd0);
        step(); check_byte("w1 b0", 4'd4, 8'hEF);
        step(); check_byte("w1 b1", 4'd5, 8'hBE);
        step(); check_byte("w1 b2", 4'd6, 8'hAD);
        step(); check_byte("w1 b3", 4'd7, 8'hDE);
        step();
        check("run entry",        {31'd0, run}, 32'd1);
        check("run entry pc",     pc, 32'd0);
        check("run ready",        {31'd0, load_ready}, 32'd0);
        check("run mem_we",       {31'd0, mem_we}, 32'd0);

        // Sequential fetch with wrap at 16 bytes; load_valid stays high and is ignored.
        step(); check("pc seq 4",  pc, 32'd4);
        step(); check("pc seq 8",  pc, 32'd8);
        step(); check("pc seq 12", pc, 32'd12);
        step(); check("pc wrap 0", pc, 32'd0);
        check("ignored load we", {31'd0, mem_we}, 32'd0);
        load_valid = 1'b0;

        stall = 1'b1;
        step(); check("stall 1", pc, 32'd0);
        step(); check("stall 2", pc, 32'd0);
        branch_taken = 1'b1; branch_target = 32'd8;
        step(); check("stall over branch", pc, 32'd0);
        stall = 1'b0;
        step(); check("branch 8", pc, 32'd8);
        branch_taken = 1'b0;
        step(); check("after branch", pc, 32'd12);
        branch_taken = 1'b1; branch_target = 32'h0000_0114;
        step(); check("branch modulo", pc, 32'd4);
        branch_taken = 1'b0;
        step(); check("pc 8 again", pc, 32'd8);

        branch_taken = 1'b1; branch_target = 32'h6;
        step();
`ifdef IMEM_ALIGN_CHECK_EN
        check("misalign pc held", pc, 32'd8);
        check("misalign pc_err",  {31'd0, pc_err}, 32'd1);
        check("misalign run",     {31'd0, run}, 32'd0);
        branch_taken = 1'b0;
        step();
        check("halt sticky pc",   pc, 32'd8);
        check("halt sticky err",  {31'd0, pc_err}, 32'd1);
        check("halt mem_we",      {31'd0, mem_we}, 32'd0);
`else
        check("misalign forced",  pc, 32'd4);
        check("misalign pc_err",  {31'd0, pc_err}, 32'd0);
        check("misalign run",     {31'd0, run}, 32'd1);
        branch_taken = 1'b0;
        step();
        check("post misalign pc", pc, 32'd8);
`endif

        // Write pointer wraps from 15 to 0 on the fifth word.
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("reload reset pc", pc, 32'd0);
        load_valid = 1'b1;
        for (int w = 0; w < 5; w++) begin
            load_data = 32'(w);
            load_last = (w == 4);
            step();
            check("wrap first addr", {28'd0, mem_waddr}, 32'((w * 4) % 16));
            step(); step(); step();
            check("wrap last addr",  {28'd0, mem_waddr}, 32'((w * 4 + 3) % 16));
            step();
        end
        load_valid = 1'b0;
        check("wrap run", {31'd0, run}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
